vga_font_renderer: RTL and testbench



---
 rtl/rom.sv | 39 +++
 rtl/vga_font_renderer.sv | 151 +++++++++++++++
 tb/tb_vga_font_renderer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rom.sv
// Synchronous-read glyph ROM: data appears one clock after the address.
// Contents are a built-in pattern (address bits XOR-folded onto the word).
module rom #(
  parameter int    ROM_WIDTH     = 8,
  parameter int    ROM_ADDR_BITS = 12,
  parameter string BLOCK_TYPE    = "block",
  parameter string PATH          = ""
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic [ROM_ADDR_BITS-1:0] i_addr,
  output logic [ROM_WIDTH-1:0]     o_data
);

  localparam int CHUNKS = (ROM_ADDR_BITS + ROM_WIDTH - 1) / ROM_WIDTH;

  logic [ROM_WIDTH-1:0] r_data;

  function automatic logic [ROM_WIDTH-1:0] fold_addr(input logic [ROM_ADDR_BITS-1:0] a);
    logic [ROM_WIDTH-1:0] w;
    w = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      w = w ^ ROM_WIDTH'(a >> (c * ROM_WIDTH));
    end
    return w;
  endfunction

  // NOTE: ROM storage carries no reset; only control state needs a known value.
  always_ff @(posedge clk) begin
    if (i_en) r_data <= fold_addr(i_addr);
  end

  assign o_data = r_data;

  // BLOCK_TYPE and PATH steer vendor mapping and file init; this model ignores them.
  logic w_unused;
  assign w_unused = (BLOCK_TYPE == "") ^ (PATH == "");

endmodule

// File: rtl/vga_font_renderer.sv
// Glyph-row serializer: request -> ROM fetch -> GLYPH_W colour pixels, gapless.
// Optional blink attribute support is compiled in with `define VGA_FONT_BLINK_EN.
module vga_font_renderer #(
  parameter int    GLYPH_W      = 8,
  parameter int    GLYPH_H      = 16,
  parameter int    NUM_CHARS    = 256,
  parameter int    COLOR_BITS   = 12,
  parameter int    BLINK_PERIOD = 32,
  parameter string PATH         = "",
  localparam int   CHAR_BITS    = $clog2(NUM_CHARS),
  localparam int   ROW_BITS     = $clog2(GLYPH_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CHAR_BITS-1:0]  req_char,
  input  logic [ROW_BITS-1:0]   req_row,
  input  logic [COLOR_BITS-1:0] req_fg,
  input  logic [COLOR_BITS-1:0] req_bg,
  input  logic [2:0]            req_attr,
  output logic                  pix_valid,
  output logic [COLOR_BITS-1:0] pix_color,
  output logic                  pix_last
);

  localparam int CNT_BITS = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(GLYPH_W - 1);

  logic                  w_accept, w_s2_load, w_hide, w_on;
  logic                  w_s1_full_next, w_busy_next;
  logic [CNT_BITS-1:0]   w_cnt_next;
  logic [GLYPH_W-1:0]    w_rom_word;

  // S0: request side-band registered alongside the ROM read
  logic                  r_a_v, r_a_blank, r_a_inv, r_a_ul;
  logic [COLOR_BITS-1:0] r_a_fg, r_a_bg;
  // S1: fetch register
  logic                  r_f_v, r_f_inv, r_f_ul;
  logic [GLYPH_W-1:0]    r_f_word;
  logic [COLOR_BITS-1:0] r_f_fg, r_f_bg;
  // S2: shifter
  logic                  r_busy, r_sh_inv, r_sh_ul;
  logic [CNT_BITS-1:0]   r_cnt;
  logic [GLYPH_W-1:0]    r_sh_word;
  logic [COLOR_BITS-1:0] r_sh_fg, r_sh_bg;

  rom #(
    .ROM_WIDTH    (GLYPH_W),
    .ROM_ADDR_BITS(CHAR_BITS + ROW_BITS),
    .BLOCK_TYPE   ("block"),
    .PATH         (PATH)
  ) u_rom (
    .clk   (clk),
    .i_en  (1'b1),
    .i_addr({req_char, req_row}),
    .o_data(w_rom_word)
  );

  assign w_s2_load      = r_f_v && (!r_busy || r_cnt == CNT_LAST);
  assign w_busy_next    = w_s2_load || (r_busy && r_cnt != CNT_LAST);
  assign w_cnt_next     = w_s2_load ? '0 : r_cnt + 1'b1;
  assign w_s1_full_next = r_a_v || (r_f_v && !w_s2_load);

  // S0 always moves into S1 next edge, so accept only if S1 will have room then.
  assign req_ready = !rst && (!w_s1_full_next || !w_busy_next || w_cnt_next == CNT_LAST);
  assign w_accept  = req_valid && req_ready;

  // NOTE: sequential state uses non-blocking assignments and a synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_v  <= 1'b0;
      r_f_v  <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_a_v  <= w_accept;
      if (r_a_v)          r_f_v <= 1'b1;
      else if (w_s2_load) r_f_v <= 1'b0;
      r_busy <= w_busy_next;
      r_cnt  <= w_busy_next ? w_cnt_next : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_blank <= (int'(req_char) >= NUM_CHARS) || (int'(req_row) >= GLYPH_H);
      r_a_inv   <= req_attr[0];
      r_a_ul    <= req_attr[1] && (int'(req_row) == GLYPH_H - 2);
      r_a_fg    <= req_fg;
      r_a_bg    <= req_bg;
    end
    if (r_a_v) begin
      r_f_word <= r_a_blank ? '0 : w_rom_word;
      r_f_inv  <= r_a_inv;
      r_f_ul   <= r_a_ul;
      r_f_fg   <= r_a_fg;
      r_f_bg   <= r_a_bg;
    end
    if (w_s2_load) begin
      r_sh_word <= r_f_word;
      r_sh_inv  <= r_f_inv;
      r_sh_ul   <= r_f_ul && !w_hide;
      r_sh_fg   <= w_hide ? r_f_bg : r_f_fg;
      r_sh_bg   <= r_f_bg;
    end else if (r_busy) begin
      r_sh_word <= r_sh_word << 1;
    end
  end

`ifdef VGA_FONT_BLINK_EN
  localparam int FC_BITS = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  logic [FC_BITS-1:0] r_frame_cnt;
  logic               r_blink_phase, r_a_blink, r_f_blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (r_frame_cnt == FC_BITS'(BLINK_PERIOD - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_a_blink <= req_attr[2];
    if (r_a_v)    r_f_blink <= r_a_blink;
  end

  // Phase is consumed only at S2 load, so a row never changes mid-way.
  assign w_hide = r_f_blink && r_blink_phase;
`else
  assign w_hide = 1'b0;

  logic w_unused;
  assign w_unused = &{1'b0, frame_start, req_attr[2], (BLINK_PERIOD != 0)};
`endif

  assign w_on      = (r_sh_word[GLYPH_W-1] | r_sh_ul) ^ r_sh_inv;
  assign pix_valid = !rst && r_busy;
  assign pix_color = pix_valid ? (w_on ? r_sh_fg : r_sh_bg) : '0;
  assign pix_last  = pix_valid && (r_cnt == CNT_LAST);

endmodule

// File: tb/tb_vga_font_renderer.sv
// Scoreboard bench for vga_font_renderer (GLYPH_H=12, NUM_CHARS=200, BLINK_PERIOD=2).
// Expected glyph words are hand-folded from {char,row} by the ROM's XOR pattern.
module tb_vga_font_renderer;

  localparam int CB = 12;

`ifdef VGA_FONT_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_char = '0;
  logic [3:0]    req_row = '0;
  logic [CB-1:0] req_fg = '0;
  logic [CB-1:0] req_bg = '0;
  logic [2:0]    req_attr = '0;
  logic          pix_valid, pix_last;
  logic [CB-1:0] pix_color;

  vga_font_renderer #(
    .GLYPH_W(8), .GLYPH_H(12), .NUM_CHARS(200), .COLOR_BITS(CB),
    .BLINK_PERIOD(2), .PATH("")
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_char(req_char), .req_row(req_row),
    .req_fg(req_fg), .req_bg(req_bg), .req_attr(req_attr),
    .pix_valid(pix_valid), .pix_color(pix_color), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CB-1:0] color;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   failures = 0;
  int   tail = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented pixel is matched against the oldest expectation.
  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pixel", 32'(pix_valid), 32'd0);
      end else begin
        m_e = sb.pop_front();
        check("pix_color", 32'(pix_color), 32'(m_e.color));
        check("pix_last", 32'(pix_last), 32'(m_e.last));
        check("pix_cycle", cyc, m_e.cyc);
      end
    end
  end

  // mask: hand-computed on/off per pixel, MSB = leftmost.
  task automatic send(input logic [7:0] ch, input logic [3:0] row, input logic [2:0] attr,
                      input logic [CB-1:0] fg, input logic [CB-1:0] bg,
                      input logic [7:0] mask, output int acc);
    int t;
    int first;
    @(negedge clk);
    req_valid = 1'b1;
    req_char  = ch;
    req_row   = row;
    req_attr  = attr;
    req_fg    = fg;
    req_bg    = bg;
    #1;
    t = 0;
    while (req_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc   = cyc + 1;
    first = (tail >= acc + 2) ? tail + 1 : acc + 2;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{color: mask[3'(7 - i)] ? fg : bg, last: (i == 7), cyc: first + i});
    end
    tail = first + 7;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    check("drain", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_color"}, 32'(pix_color), 32'd0);
    check({tag, "_last"}, 32'(pix_last), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  int a0, a1, a2, ar;

  initial begin
    req_valid = 1'b1;
    req_char  = 8'h41;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;

    // Single request: 0x41/5 -> word 0x11, first pixel two edges after accept.
    send(8'h41, 4'd5, 3'b000, 12'hFFF, 12'h000, 8'h11, a0);
    idle();
    drain();

    // Three requests held valid: accepts at +1 then +8, 24 gapless pixels.
    send(8'h12, 4'd3,  3'b000, 12'h0F0, 12'h00F, 8'h22, a0);
    send(8'hA5, 4'd0,  3'b000, 12'hF00, 12'h111, 8'h5A, a1);
    send(8'h7E, 4'd11, 3'b000, 12'hABC, 12'h123, 8'hEC, a2);
    idle();
    drain();
    check("b2b_gap1", a1 - a0, 32'd1);
    check("b2b_gap2", a2 - a1, 32'd8);

    // Attributes and blanking (underline row is GLYPH_H-2 = 10).
    send(8'h33, 4'd10, 3'b011, 12'hFFF, 12'h000, 8'h00, a0);
    send(8'h33, 4'd10, 3'b010, 12'h5A5, 12'h000, 8'hFF, a0);
    send(8'h33, 4'd9,  3'b010, 12'h777, 12'h888, 8'h3A, a0);
    send(8'h41, 4'd5,  3'b001, 12'hFFF, 12'h000, 8'hEE, a0);
    send(8'hFA, 4'd2,  3'b000, 12'hFFF, 12'h246, 8'h00, a0);
    send(8'h41, 4'd13, 3'b000, 12'hFFF, 12'h135, 8'h00, a0);
    send(8'hFA, 4'd2,  3'b001, 12'hFFF, 12'h246, 8'hFF, a0);
    idle();
    drain();

    // Reset during pixel 3: pixels 0..2 seen, nothing afterwards.
    send(8'h41, 4'd5, 3'b000, 12'hFFF, 12'h000, 8'h11, ar);
    idle();
    while (cyc < ar + 5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    check("flush_remaining", sb.size(), 32'd5);
    sb.delete();
    tail = -1;
    @(negedge clk);
    check_quiet("midrow_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(8'h12, 4'd3, 3'b000, 12'h0F0, 12'h00F, 8'h22, a0);
    idle();
    drain();

    // Blink attribute across frame pulses (BLINK_PERIOD = 2).
    send(8'h41, 4'd5, 3'b100, 12'hFFF, 12'h000, 8'h11, a0);
    idle();
    drain();
    pulse_frame();
    pulse_frame();
    send(8'h41, 4'd5, 3'b100, 12'hFFF, 12'h000, BLINK_ON ? 8'h00 : 8'h11, a0);
    send(8'h41, 4'd5, 3'b101, 12'hFFF, 12'h000, BLINK_ON ? 8'h00 : 8'hEE, a0);
    idle();
    drain();
    pulse_frame();
    pulse_frame();
    send(8'h41, 4'd5, 3'b100, 12'hFFF, 12'h000, 8'h11, a0);
    idle();
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
